// File: rtl/switch_input_conditioner_pkg.sv
// Shared constants for the slide-switch conditioner: clock rate, default
// debounce interval and the byte slices that feed the num1/num2 operands.
package switch_input_conditioner_pkg;

   localparam int CLK_HZ              = 10_000_000;
   localparam int DEBOUNCE_MS         = 10;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;

   localparam int NUM1_MSB = 7;
   localparam int NUM1_LSB = 0;
   localparam int NUM2_MSB = 15;
   localparam int NUM2_LSB = 8;

endpackage

// File: rtl/switch_input_conditioner_debounce_bit.sv
// One switch bit: two-flop synchroniser, persistence counter and stable flop.
// update is high during the cycle whose closing edge loads the new stable level.
module debounce_bit
   import switch_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 17
) (
   input  logic clock,
   input  logic reset,
   input  logic sw_raw,
   output logic stable,
   output logic update
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic             differs;

   assign differs = (s2 != stable);
   assign update  = differs && (cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
         // Any return to the stable level discards the partial count.
         if (!differs) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_input_conditioner.sv
// Conditions the board slide switches into debounced operands num1/num2 and
// reports updates through a one-cycle pulse and a sticky, clearable mask.
module switch_input_conditioner
   import switch_input_conditioner_pkg::*;
#(
   parameter int N_SW            = 16,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 17
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_SW-1:0] sw_raw,
   input  logic            clear_pending,
   output logic [N_SW-1:0] sw_stable,
   output logic [31:0]     num1,
   output logic [31:0]     num2,
   output logic            sw_changed,
   output logic [N_SW-1:0] changed_mask,
   output logic            change_pending
);

   logic [N_SW-1:0] update;

   for (genvar i = 0; i < N_SW; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce_bit (
         .clock  (clock),
         .reset  (reset),
         .sw_raw (sw_raw[i]),
         .stable (sw_stable[i]),
         .update (update[i])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sw_changed   <= 1'b0;
         changed_mask <= '0;
      end else begin
         sw_changed   <= |update;
         // A bit updating on the clearing edge stays recorded.
         changed_mask <= (clear_pending ? '0 : changed_mask) | update;
      end
   end

   assign num1           = {24'b0, sw_stable[NUM1_MSB:NUM1_LSB]};
   assign num2           = {24'b0, sw_stable[NUM2_MSB:NUM2_LSB]};
   assign change_pending = |changed_mask;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Directed bench for switch_input_conditioner with a short debounce interval.
module tb_switch_input_conditioner;

   localparam int N_SW = 16;
   localparam int DC   = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic [N_SW-1:0] sw_raw;
   logic            clear_pending;
   logic [N_SW-1:0] sw_stable;
   logic [31:0]     num1;
   logic [31:0]     num2;
   logic            sw_changed;
   logic [N_SW-1:0] changed_mask;
   logic            change_pending;

   int vectors     = 0;
   int miscompares = 0;

   switch_input_conditioner #(
      .N_SW            (N_SW),
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (3)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .sw_raw         (sw_raw),
      .clear_pending  (clear_pending),
      .sw_stable      (sw_stable),
      .num1           (num1),
      .num2           (num2),
      .sw_changed     (sw_changed),
      .changed_mask   (changed_mask),
      .change_pending (change_pending)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [15:0] st, input logic ch,
                            input logic [15:0] mask);
      check({tag, ".sw_stable"}, 32'(sw_stable), 32'(st));
      check({tag, ".num1"}, num1, {24'b0, st[7:0]});
      check({tag, ".num2"}, num2, {24'b0, st[15:8]});
      check({tag, ".sw_changed"}, 32'(sw_changed), 32'(ch));
      check({tag, ".changed_mask"}, 32'(changed_mask), 32'(mask));
      check({tag, ".change_pending"}, 32'(change_pending), 32'(|mask));
   endtask

   task automatic clear_mask();
      clear_pending = 1'b1;
      step(1);
      clear_pending = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      sw_raw        = 16'hFFFF;
      clear_pending = 1'b0;

      // Reset held with all switches high.
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_all("rst_hold", 16'h0000, 1'b0, 16'h0000);
      end
      reset = 1'b0;
      step(DC + 1);
      check_all("rst_rel_pre", 16'h0000, 1'b0, 16'h0000);
      step(1);
      check_all("rst_rel_upd", 16'hFFFF, 1'b1, 16'hFFFF);
      step(1);
      check_all("rst_rel_post", 16'hFFFF, 1'b0, 16'hFFFF);

      // Clear with no activity.
      clear_mask();
      check_all("clear_only", 16'hFFFF, 1'b0, 16'h0000);

      sw_raw = 16'h0000;
      step(DC + 2);
      check_all("fall_all", 16'h0000, 1'b1, 16'hFFFF);
      clear_mask();

      // Clean change.
      sw_raw = 16'h12A5;
      step(DC + 1);
      check_all("clean_pre", 16'h0000, 1'b0, 16'h0000);
      step(1);
      check_all("clean_upd", 16'h12A5, 1'b1, 16'h12A5);
      step(1);
      check_all("clean_post", 16'h12A5, 1'b0, 16'h12A5);
      clear_mask();

      // Bit 3 bounces: three cycles high never completes a four-cycle count.
      for (int r = 0; r < 3; r++) begin
         sw_raw = 16'h12AD;
         for (int k = 0; k < 3; k++) begin
            step(1);
            check_all("bounce_hi", 16'h12A5, 1'b0, 16'h0000);
         end
         sw_raw = 16'h12A5;
         for (int k = 0; k < 3; k++) begin
            step(1);
            check_all("bounce_lo", 16'h12A5, 1'b0, 16'h0000);
         end
      end
      sw_raw = 16'h12AD;
      step(DC + 1);
      check_all("hold_pre", 16'h12A5, 1'b0, 16'h0000);
      step(1);
      check_all("hold_upd", 16'h12AD, 1'b1, 16'h0008);
      clear_mask();

      // Clear collides with a bit-8 update.
      sw_raw = 16'h12AC;
      step(DC + 2);
      check_all("coll_setup", 16'h12AC, 1'b1, 16'h0001);
      sw_raw = 16'h13AC;
      step(DC + 1);
      check_all("coll_pre", 16'h12AC, 1'b0, 16'h0001);
      clear_pending = 1'b1;
      step(1);
      clear_pending = 1'b0;
      check_all("coll_upd", 16'h13AC, 1'b1, 16'h0100);
      clear_mask();

      // Reset while bit 0 is mid-count.
      sw_raw = 16'h13AD;
      step(4);
      check_all("midcnt_pre", 16'h13AC, 1'b0, 16'h0000);
      reset = 1'b1;
      step(1);
      check_all("midcnt_rst", 16'h0000, 1'b0, 16'h0000);
      reset = 1'b0;
      step(DC + 1);
      check_all("midcnt_rel_pre", 16'h0000, 1'b0, 16'h0000);
      step(1);
      check_all("midcnt_rel_upd", 16'h13AD, 1'b1, 16'h13AD);
      step(1);
      check_all("midcnt_rel_post", 16'h13AD, 1'b0, 16'h13AD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
